// File: rtl/music_pkg.sv
// Shared types and helpers for the melody playback controller.
package music_pkg;

  localparam int unsigned NOTE_W_DEF = 4;
  localparam int unsigned NOTE_REST  = 0;
  localparam int unsigned PRESC_W    = 23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_PAUSED,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TEMPO_BASE = 2'd0,
    TEMPO_X2   = 2'd1,
    TEMPO_X4   = 2'd2,
    TEMPO_HALF = 2'd3
  } tempo_e;

  // Terminal prescaler count for a tempo code; never below 0 even for tiny bases.
  function automatic logic [PRESC_W-1:0] step_last(input int unsigned base,
                                                   input logic [1:0] sel);
    int unsigned len;
    case (sel)
      TEMPO_X2:   len = base / 2;
      TEMPO_X4:   len = base / 4;
      TEMPO_HALF: len = base * 2;
      default:    len = base;
    endcase
    if (len == 0) len = 1;
    return PRESC_W'(len - 1);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Tempo-scaled step prescaler: counts 0..Pt-1 and ticks on the terminal count.
module step_timer
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 5000000,
  parameter int unsigned STEPS_PER_SEC = 4
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       clr_i,
  input  logic       freeze_i,
  input  logic [1:0] tempo_sel_i,
  output logic       tick_o
);

  localparam int unsigned BASE = CLK_HZ / STEPS_PER_SEC;

  logic [1:0]         tempo_q;
  logic [PRESC_W-1:0] cnt_q, cnt_d, last;

  // ">=" rather than "==" so a tempo change that strands the count past the new
  // terminal value still ticks on the following cycle.
  always_comb begin
    last   = step_last(BASE, tempo_q);
    tick_o = !clr_i && !freeze_i && (cnt_q >= last);
    cnt_d  = cnt_q;
    if (clr_i)          cnt_d = '0;
    else if (tick_o)    cnt_d = '0;
    else if (!freeze_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      tempo_q <= '0;
      cnt_q   <= '0;
    end else begin
      tempo_q <= tempo_sel_i;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/music_ctrl.sv
// Melody sequencer and key/melody note arbiter for the shared tone generator.
module music_ctrl
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 5000000,
  parameter int unsigned STEPS_PER_SEC = 4,
  parameter int unsigned SONG_LEN      = 16,
  parameter int unsigned NOTE_W        = NOTE_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  input  logic [NOTE_W-1:0] key_note,
  output logic [4:0]        rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [NOTE_W-1:0] note,
  output logic              speak,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] LAST_ADDR = 5'(SONG_LEN - 1);

  state_e            state_q;
  logic [4:0]        rom_addr_q;
  logic [NOTE_W-1:0] song_note_q;
  logic [NOTE_W-1:0] note_q;

  logic key_held, start_evt, pause_evt;
  logic timer_clr, timer_freeze, tick;

  always_comb begin
    key_held  = (key_note != NOTE_W'(NOTE_REST));
    start_evt = start && !stop;
    pause_evt = pause && !stop && !start;
    timer_clr = (state_q == ST_FETCH) || start_evt;
    // The pause cycle itself is frozen so the resumed step keeps the exact remaining count.
    timer_freeze = key_held
                || (state_q == ST_IDLE) || (state_q == ST_PAUSED) || (state_q == ST_DONE)
                || ((state_q == ST_PLAY) && pause_evt);
  end

  step_timer #(
    .CLK_HZ        (CLK_HZ),
    .STEPS_PER_SEC (STEPS_PER_SEC)
  ) u_timer (
    .clk_i       (clk),
    .nrst_i      (nrst),
    .clr_i       (timer_clr),
    .freeze_i    (timer_freeze),
    .tempo_sel_i (tempo_sel),
    .tick_o      (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      song_note_q <= '0;
      note_q      <= '0;
    end else begin
      if (key_held)
        note_q <= key_note;
      else if ((state_q == ST_FETCH) || (state_q == ST_PLAY))
        note_q <= song_note_q;
      else
        note_q <= NOTE_W'(NOTE_REST);

      if (stop) begin
        state_q     <= ST_IDLE;
        rom_addr_q  <= '0;
        song_note_q <= '0;
      end else if (start) begin
        state_q    <= ST_FETCH;
        rom_addr_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: song_note_q <= '0;
          ST_FETCH: begin
            song_note_q <= rom_note;
            state_q     <= ST_PLAY;
          end
          ST_PLAY: begin
            if (pause) begin
              state_q <= ST_PAUSED;
            end else if (tick) begin
              if (rom_addr_q == LAST_ADDR) begin
                if (loop_en) begin
                  rom_addr_q <= '0;
                  state_q    <= ST_FETCH;
                end else begin
                  song_note_q <= '0;
                  state_q     <= ST_DONE;
                end
              end else begin
                rom_addr_q <= rom_addr_q + 1'b1;
                state_q    <= ST_FETCH;
              end
            end
          end
          ST_PAUSED: if (pause) state_q <= ST_PLAY;
          ST_DONE: begin
            song_note_q <= '0;
            rom_addr_q  <= '0;
            state_q     <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rom_addr = rom_addr_q;
    note     = note_q;
    speak    = (note_q != NOTE_W'(NOTE_REST));
    busy     = (state_q == ST_FETCH) || (state_q == ST_PLAY) || (state_q == ST_PAUSED);
    done     = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_music_ctrl.sv
// Bench for music_ctrl with a 4-step song {3,6,10,6} at 10-cycle base steps.
module tb_music_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [3:0] key_note = 4'd0;
  logic [3:0] rom_note, note;
  logic [4:0] rom_addr;
  logic       speak, busy, done;

  logic [3:0] rom_mem [32];
  int         song_tab [4] = '{3, 6, 10, 6};

  assign rom_note = rom_mem[rom_addr];

  music_ctrl #(
    .CLK_HZ        (40),
    .STEPS_PER_SEC (4),
    .SONG_LEN      (4),
    .NOTE_W        (4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .tempo_sel (tempo_sel),
    .key_note  (key_note),
    .rom_addr  (rom_addr),
    .rom_note  (rom_note),
    .note      (note),
    .speak     (speak),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // m bits: 0 note+speak, 1 busy, 2 done, 3 rom_addr
  typedef struct {
    int       cyc;
    string    name;
    bit [3:0] m;
    int       note;
    int       busy;
    int       done;
    int       addr;
  } exp_t;

  typedef struct {
    string    name;
    bit [1:0] tempo;
    bit       loop;
    int       step_len;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string nm, input int act, input int want, input int at);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, at, act, want);
    end
  endtask

  task automatic push_exp(input int c, input string nm, input bit [3:0] m,
                          input int n, input int b, input int d, input int a);
    exp_t e;
    e.cyc = c; e.name = nm; e.m = m; e.note = n; e.busy = b; e.done = d; e.addr = a;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s missed cyc=%0d now=%0d", cur.name, cur.cyc, cyc);
      end else begin
        if (cur.m[0]) begin
          check_val({cur.name, ".note"}, int'(note), cur.note, cyc);
          check_val({cur.name, ".speak"}, int'(speak), int'(cur.note != 0), cyc);
        end
        if (cur.m[1]) check_val({cur.name, ".busy"}, int'(busy), cur.busy, cyc);
        if (cur.m[2]) check_val({cur.name, ".done"}, int'(done), cur.done, cyc);
        if (cur.m[3]) check_val({cur.name, ".addr"}, int'(rom_addr), cur.addr, cyc);
      end
    end
  end

  // Expected outputs e cycles after the edge that samples start, from an idle start.
  function automatic void model(input int e, input int len, input bit lp,
                                output int n, output int b, output int d, output int a);
    int last_edge;
    int k;
    last_edge = 4 * len;
    n = 0; b = 1; d = 0; a = 0;
    if (e >= 2) begin
      k = (e - 2) / len;
      if (lp || e <= last_edge) n = song_tab[k % 4];
    end
    if (lp) begin
      a = (e / len) % 4;
    end else begin
      b = int'(e < last_edge);
      d = int'(e == last_edge);
      a = (e <= last_edge) ? (((e / len) > 3) ? 3 : (e / len)) : 0;
    end
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick1();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) tick1();
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    tick1();
    stop = 1'b0;
    tick1();
    tick1();
  endtask

  task automatic do_start(output int s);
    s = cyc + 1;
    start = 1'b1;
    tick1();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int run;
    int n, b, d, a;

    for (int i = 0; i < 32; i++) rom_mem[i] = 4'd0;
    for (int i = 0; i < 4; i++) rom_mem[i] = 4'(song_tab[i]);

    vecs[0] = '{name: "base", tempo: 2'd0, loop: 1'b0, step_len: 11};
    vecs[1] = '{name: "x2",   tempo: 2'd1, loop: 1'b0, step_len: 6};
    vecs[2] = '{name: "x4",   tempo: 2'd2, loop: 1'b0, step_len: 3};
    vecs[3] = '{name: "slow", tempo: 2'd3, loop: 1'b0, step_len: 21};
    vecs[4] = '{name: "loop", tempo: 2'd0, loop: 1'b1, step_len: 11};

    #1 nrst = 1'b0;
    #2;
    check_val("rst.note", int'(note), 0, cyc);
    check_val("rst.speak", int'(speak), 0, cyc);
    check_val("rst.busy", int'(busy), 0, cyc);
    check_val("rst.done", int'(done), 0, cyc);
    check_val("rst.addr", int'(rom_addr), 0, cyc);
    tick1();
    nrst = 1'b1;
    tick1();

    for (int i = 0; i < 5; i++) begin
      tempo_sel = vecs[i].tempo;
      loop_en   = vecs[i].loop;
      stop_pulse();
      s   = cyc + 1;
      run = vecs[i].loop ? 12 * vecs[i].step_len + 2 : 4 * vecs[i].step_len + 4;
      for (int e = 0; e <= run; e++) begin
        model(e, vecs[i].step_len, vecs[i].loop, n, b, d, a);
        push_exp(s + e, vecs[i].name, 4'hF, n, b, d, a);
      end
      do_start(s);
      wait_until(s + run);
      drain();
    end
    loop_en   = 1'b0;
    tempo_sel = 2'd0;
    stop_pulse();

    // Tempo 0 -> 2 while the count is 7: the stranded count ticks one cycle later.
    do_start(s);
    push_exp(s + 9,  "tempo_sw", 4'b1000, 0, 0, 0, 0);
    push_exp(s + 10, "tempo_sw", 4'b1000, 0, 0, 0, 1);
    wait_until(s + 8);
    tempo_sel = 2'd2;
    wait_until(s + 11);
    drain();
    tempo_sel = 2'd0;
    stop_pulse();

    // Pause in step 1 at count 4, resume: six more PLAY cycles before the tick.
    do_start(s);
    push_exp(s + 17, "pause", 4'b0001, 6, 0, 0, 0);
    push_exp(s + 18, "pause", 4'b0011, 0, 1, 0, 0);
    push_exp(s + 23, "pause", 4'b0001, 0, 0, 0, 0);
    push_exp(s + 24, "pause", 4'b0001, 6, 0, 0, 0);
    push_exp(s + 28, "pause", 4'b1000, 0, 0, 0, 1);
    push_exp(s + 29, "pause", 4'b1000, 0, 0, 0, 2);
    wait_until(s + 16);
    pause = 1'b1;
    tick1();
    pause = 1'b0;
    wait_until(s + 22);
    pause = 1'b1;
    tick1();
    pause = 1'b0;
    wait_until(s + 30);
    drain();
    stop_pulse();

    // Key held 20 cycles mid-step overrides the note and freezes step timing.
    do_start(s);
    push_exp(s + 6,  "key", 4'b0001, 9, 0, 0, 0);
    push_exp(s + 25, "key", 4'b0001, 9, 0, 0, 0);
    push_exp(s + 26, "key", 4'b0001, 3, 0, 0, 0);
    push_exp(s + 30, "key", 4'b1000, 0, 0, 0, 0);
    push_exp(s + 31, "key", 4'b1000, 0, 0, 0, 1);
    wait_until(s + 5);
    key_note = 4'd9;
    wait_until(s + 25);
    key_note = 4'd0;
    wait_until(s + 32);
    drain();
    stop_pulse();

    // start and stop together in PLAY: stop wins.
    do_start(s);
    push_exp(s + 5, "startstop", 4'b0001, 3, 0, 0, 0);
    push_exp(s + 6, "startstop", 4'b1011, 3, 0, 0, 0);
    push_exp(s + 7, "startstop", 4'b0111, 0, 0, 0, 0);
    wait_until(s + 5);
    start = 1'b1;
    stop  = 1'b1;
    tick1();
    start = 1'b0;
    stop  = 1'b0;
    wait_until(s + 8);
    drain();
    stop_pulse();

    // start while PAUSED restarts from step 0.
    do_start(s);
    push_exp(s + 16, "restart", 4'b0011, 0, 1, 0, 0);
    push_exp(s + 17, "restart", 4'b1011, 0, 1, 0, 0);
    push_exp(s + 18, "restart", 4'b0001, 6, 0, 0, 0);
    push_exp(s + 19, "restart", 4'b0001, 3, 0, 0, 0);
    push_exp(s + 27, "restart", 4'b1000, 0, 0, 0, 0);
    push_exp(s + 28, "restart", 4'b1000, 0, 0, 0, 1);
    wait_until(s + 14);
    pause = 1'b1;
    tick1();
    pause = 1'b0;
    wait_until(s + 16);
    start = 1'b1;
    tick1();
    start = 1'b0;
    wait_until(s + 29);
    drain();
    stop_pulse();

    // Asynchronous reset in PLAY clears outputs without a clock edge.
    do_start(s);
    wait_until(s + 20);
    check_val("arst.pre_note", int'(note), 6, cyc);
    check_val("arst.pre_busy", int'(busy), 1, cyc);
    #2 nrst = 1'b0;
    #1;
    check_val("arst.note", int'(note), 0, cyc);
    check_val("arst.speak", int'(speak), 0, cyc);
    check_val("arst.busy", int'(busy), 0, cyc);
    check_val("arst.done", int'(done), 0, cyc);
    check_val("arst.addr", int'(rom_addr), 0, cyc);
    tick1();
    nrst = 1'b1;
    tick1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/music_ctrl.md
Name: music_ctrl

Overview:
- Playback controller and arbiter for the board's single tone generator, clocked at 5 MHz.
- Sequences a melody stored in an external synchronous note ROM: generates ROM addresses, times each musical step with a tempo-scaled prescaler, and handles play, pause, stop and loop.
- Arbitrates the note output between the melody and a manual key input; the key always has priority.
- Output note/speak pair feeds the existing note-to-frequency tone generator.

Parameters:
- CLK_HZ, 5000000, source clock frequency in Hz.
- STEPS_PER_SEC, 4, musical steps per second at tempo_sel=0.
- SONG_LEN, 16, number of ROM entries in the melody (2..32).
- NOTE_W, 4, note index width; index 0 means rest.

Ports:
- clk  in  1  source clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; start or restart the melody from step 0.
- stop  in  1  single-cycle pulse; abort playback and go to IDLE.
- pause  in  1  single-cycle pulse; toggle PLAY and PAUSED.
- loop_en  in  1  at the last step, wrap to step 0 instead of finishing.
- tempo_sel  in  2  0=base, 1=x2 faster, 2=x4 faster, 3=x2 slower.
- key_note  in  NOTE_W  manual key note; nonzero means a key is held.
- rom_addr  out  5  melody ROM address, registered.
- rom_note  in  NOTE_W  ROM data, valid exactly 1 cycle after rom_addr changes.
- note  out  NOTE_W  note index to the tone generator, registered.
- speak  out  1  high when note != 0.
- busy  out  1  high in FETCH, PLAY or PAUSED.
- done  out  1  one-cycle pulse when a non-looping melody completes.

Behaviour:
- Reset (async, nrst=0): state=IDLE, rom_addr=0, note=0, speak=0, busy=0, done=0, prescaler=0, song_note=0.
- Step period P = CLK_HZ/STEPS_PER_SEC cycles, scaled by tempo_sel to P, P/2, P/4 or 2P.
- Prescaler is 23 bits and counts 0..Pt-1; tick fires on the cycle the count equals Pt-1, then the count returns to 0.
- tempo_sel is sampled each cycle. If a change leaves the count >= Pt-1, the tick fires on the next cycle.
- Prescaler is cleared on entry to FETCH. It is frozen in IDLE, PAUSED, and whenever key_note != 0.
- States:
  - IDLE: song_note=0. On start: rom_addr<=0, go to FETCH.
  - FETCH (exactly 1 cycle): ROM settles. Next edge: song_note<=rom_note, go to PLAY. The previous song_note is held during FETCH, so there is no gap.
  - PLAY: on pause, go to PAUSED. On tick with rom_addr < SONG_LEN-1: rom_addr+1, go to FETCH. On tick with rom_addr == SONG_LEN-1: if loop_en, rom_addr<=0 and go to FETCH; otherwise go to DONE.
  - PAUSED: song_note is silenced at the output and the prescaler keeps its count. On pause, return to PLAY and resume with the remaining count.
  - DONE (1 cycle): done=1, song_note=0, rom_addr<=0, then go to IDLE.
- Event priority within one cycle: stop > start > pause.
  - stop in any state: go to IDLE, rom_addr=0, song_note=0, no done pulse.
  - start in FETCH, PLAY, PAUSED or DONE restarts from step 0 (FETCH, prescaler cleared).
  - pause in IDLE, FETCH or DONE is ignored.
- Output arbitration (registered, 1-cycle latency from inputs and state):
  - note <= key_note when key_note != 0.
  - Otherwise note <= song_note in FETCH or PLAY, and 0 in all other states.
- speak is combinational from the registered note.
- Holding a key freezes melody timing. On release, the melody resumes with the remaining step time.
- Latency: start at edge 0 gives FETCH at edge 1, PLAY and song_note at edge 2, first song note on the note output after edge 3.
- Each step lasts Pt+1 cycles: Pt in PLAY plus 1 in FETCH.

Decomposition:
- Package music_pkg: state encoding (IDLE, FETCH, PLAY, PAUSED, DONE), NOTE_REST=0, tempo_sel codes, and an NOTE_W default.
- Sub-module step_timer: tempo-scaled prescaler with clear and freeze inputs and a tick output, parameterised by CLK_HZ and STEPS_PER_SEC.
- The FSM, address counter and output arbiter stay in music_ctrl.

Test Plan (CLK_HZ=40, STEPS_PER_SEC=4, SONG_LEN=4, ROM contents {3,6,10,6}):
- Basic play:
  - Stimulus: reset, start pulse, loop_en=0, tempo_sel=0.
  - Response: note=3 from cycle 3; each note lasts 11 cycles (sequence 3,6,10,6); then done pulses once, note=0, busy=0, rom_addr=0.
- Tempo:
  - tempo_sel=1 gives 6-cycle steps; tempo_sel=3 gives 21-cycle steps.
  - Switching tempo_sel 0 to 2 when the count is 7 makes the tick fire on the next cycle.
- Loop:
  - Stimulus: loop_en=1.
  - Response: after step 3, rom_addr wraps to 0 and note returns to 3 with no done pulse; the sequence repeats 3 times correctly.
- Pause and key override:
  - pause in step 1 at count 4 makes note 0; pause again gives 6 more PLAY cycles before the tick.
  - key_note=9 held for 20 cycles mid-step gives note=9 and speak=1, and the melody step is not advanced.
- Simultaneous and mid-operation events:
  - start and stop in the same cycle during PLAY: go to IDLE, note=0.
  - start in PAUSED: restart at rom_addr=0.
  - nrst asserted in PLAY: all outputs 0 immediately, asynchronously.
